dma_mem_responder: RTL and testbench

DMA_MEM_RESPONDER -- requirements
Module: dma_mem_responder

---
 rtl/dma_mem_responder.sv | 178 +++++++++++++++++
 tb/tb_dma_mem_responder.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_mem_responder.sv
// ---------------------------------------------------------------------------
// dma_mem_responder
//
// Services one DMA transfer at a time against a single-port 64-bit SRAM that
// has 1-cycle read latency.
// - Writes stream in on wr_*. Each accepted beat goes straight to the SRAM in
//   the same cycle.
// - Reads issue one SRAM access, wait one cycle for the data, then present the
//   word on rd_*. This gives one word every 3 cycles when the consumer never
//   stalls.
// - Every request ends with a one-cycle ack. err is set on that ack if the
//   request was rejected.
// - After the ack, the block waits for req to drop before it accepts another
//   request.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req, rw, addr, len          request: level req, 1=write, byte address,
//                               length in 64-bit words
//   ack, err, busy              completion pulse, reject flag, in-flight flag
//   wr_valid, wr_data, wr_ready write data stream (into memory)
//   rd_valid, rd_data, rd_ready read data stream (out of memory)
//   mem_en, mem_we, mem_addr,   SRAM port (word addressed)
//   mem_wdata, mem_rdata
// ---------------------------------------------------------------------------
module dma_mem_responder #(
  parameter int ADDR_W  = 13,
  parameter int MAX_LEN = 8192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              rw,
  input  logic [47:0]       addr,
  input  logic [31:0]       len,
  output logic              ack,
  output logic              err,
  output logic              busy,
  input  logic              wr_valid,
  input  logic [63:0]       wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [63:0]       rd_data,
  input  logic              rd_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_OUT, ACK, DROP
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [31:0]         len_q, len_d;
  logic [31:0]         count_q, count_d;
  logic                err_q, err_d;
  logic [63:0]         rd_data_q, rd_data_d;

  logic [ADDR_W-1:0]   word_addr;
  logic                last_beat;
  logic                req_legal;

  // The byte offset within a word and the address bits above the SRAM range
  // take no part in addressing. The offset is only checked for alignment.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[47:ADDR_W+3];

  // The sum is truncated to ADDR_W bits, so a burst that runs past the top
  // word wraps to word 0.
  assign word_addr = base_q + count_q[ADDR_W-1:0];
  assign last_beat = (count_q == len_q - 32'd1);
  assign req_legal = (len != 32'd0) && (len <= 32'(MAX_LEN)) &&
                     (addr[2:0] == 3'b000);

  assign rd_data = rd_data_q;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    count_d   = count_q;
    err_d     = err_q;
    rd_data_d = rd_data_q;

    ack       = 1'b0;
    err       = 1'b0;
    busy      = (state_q != IDLE);
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      IDLE: begin
        if (req) begin
          base_d  = addr[ADDR_W+2:3];
          len_d   = len;
          count_d = 32'd0;
          err_d   = !req_legal;
          if (!req_legal) state_d = ACK;
          else if (rw)    state_d = WRITE;
          else            state_d = RD_ISSUE;
        end
      end

      WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = word_addr;
          mem_wdata = wr_data;
          count_d   = count_q + 32'd1;
          if (last_beat) state_d = ACK;
        end
      end

      RD_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = word_addr;
        state_d  = RD_WAIT;
      end

      RD_WAIT: begin
        // SRAM data for the access issued last cycle is valid now.
        rd_data_d = mem_rdata;
        state_d   = RD_OUT;
      end

      RD_OUT: begin
        rd_valid = 1'b1;
        if (rd_ready) begin
          count_d = count_q + 32'd1;
          state_d = last_beat ? ACK : RD_ISSUE;
        end
      end

      ACK: begin
        ack     = 1'b1;
        err     = err_q;
        state_d = DROP;
      end

      DROP: begin
        // A req that is still held from the finished transfer must not
        // start a second one.
        if (!req) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      base_q    <= '0;
      len_q     <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      count_q   <= count_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_dma_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_dma_mem_responder
//
// Randomised bench for dma_mem_responder.
// - A behavioural SRAM with 1-cycle read latency backs the DUT.
// - A separate reference array (ref_mem) holds the contents the memory should
//   have, based on the transfers issued so far.
// - Stimulus tasks push the expected SRAM writes, read words and ack/err
//   values into queues.
// - The monitor pops those queues whenever the DUT shows a write beat, a read
//   handshake or an ack, and compares the values.
// ---------------------------------------------------------------------------
module tb_dma_mem_responder;

  localparam int ADDR_W  = 13;
  localparam int MAX_LEN = 8192;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req, rw;
  logic [47:0]       addr;
  logic [31:0]       len;
  logic              ack, err, busy;
  logic              wr_valid, wr_ready;
  logic [63:0]       wr_data;
  logic              rd_valid, rd_ready;
  logic [63:0]       rd_data;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata, mem_rdata;

  dma_mem_responder #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .rw(rw), .addr(addr), .len(len),
    .ack(ack), .err(err), .busy(busy),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM that the DUT drives.
  logic [63:0] sram    [DEPTH];
  // Reference contents, updated by the stimulus tasks.
  logic [63:0] ref_mem [DEPTH];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [63:0]       d;
  } wr_t;

  wr_t         exp_wr[$];
  logic [63:0] exp_rd[$];
  logic        exp_err[$];

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  int acks_seen = 0;
  int ack_cyc = 0;
  int mem_en_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none (t=%0t)", name, $time);
  endtask

  // ------------------------------------------------------------------ monitor
  logic        prev_rv, prev_rr, prev_ack;
  logic [63:0] prev_rd;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rv  = 1'b0;
      prev_rr  = 1'b0;
      prev_ack = 1'b0;
      prev_rd  = '0;
    end else begin
      if (mem_en) mem_en_cnt++;
      if (mem_en && mem_we) begin
        if (exp_wr.size() == 0) fail_event("wr_unexpected");
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_addr", 64'(mem_addr), 64'(e.a));
          chk("wr_data", mem_wdata, e.d);
        end
      end
      if (rd_valid) chk("rd_out_mem_en", 64'(mem_en), 64'(0));
      if (prev_rv && !prev_rr && rd_valid) chk("rd_hold", rd_data, prev_rd);
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) fail_event("rd_unexpected");
        else chk("rd_data", rd_data, exp_rd.pop_front());
      end
      if (ack) begin
        acks_seen++;
        ack_cyc = cyc_cnt;
        chk("ack_pulse", 64'(prev_ack), 64'(0));
        if (exp_err.size() == 0) fail_event("ack_unexpected");
        else chk("ack_err", 64'(err), 64'(exp_err.pop_front()));
      end else begin
        chk("err_quiet", 64'(err), 64'(0));
      end
      prev_rv  = rd_valid;
      prev_rr  = rd_ready;
      prev_rd  = rd_data;
      prev_ack = ack;
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic check_all_zero(input string tag);
    chk({tag, "_ack"},       64'(ack), 64'(0));
    chk({tag, "_err"},       64'(err), 64'(0));
    chk({tag, "_busy"},      64'(busy), 64'(0));
    chk({tag, "_wr_ready"},  64'(wr_ready), 64'(0));
    chk({tag, "_rd_valid"},  64'(rd_valid), 64'(0));
    chk({tag, "_rd_data"},   rd_data, 64'(0));
    chk({tag, "_mem_en"},    64'(mem_en), 64'(0));
    chk({tag, "_mem_we"},    64'(mem_we), 64'(0));
    chk({tag, "_mem_addr"},  64'(mem_addr), 64'(0));
    chk({tag, "_mem_wdata"}, mem_wdata, 64'(0));
  endtask

  // Called at posedge+1 with the DUT in IDLE. Returns at posedge+1 after the
  // latching edge, with the request fields scrambled so that later changes
  // to them are exercised.
  task automatic start_req(input logic w, input logic [47:0] a, input int n);
    req  = 1'b1;
    rw   = w;
    addr = a;
    len  = 32'(n);
    @(posedge clk); #1;
    rw   = 1'($urandom);
    addr = 48'({$urandom, $urandom});
    len  = $urandom;
    req  = 1'($urandom_range(0, 1));
  endtask

  // Called at posedge+1 with the DUT in DROP.
  task automatic finish_req();
    chk("drop_busy", 64'(busy), 64'(1));
    if (req) begin
      int k;
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) begin
        @(posedge clk); #1;
        chk("drop_hold_busy", 64'(busy), 64'(1));
        chk("drop_hold_ack", 64'(ack), 64'(0));
      end
    end
    req = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", 64'(busy), 64'(0));
  endtask

  task automatic do_write(input logic [47:0] a, input int n, input bit gaps, input int abort_k);
    logic [63:0]       d[$];
    logic [ADDR_W-1:0] base;
    int a0, m0, i, cyc, first, last, limit;
    bit done;
    base  = a[ADDR_W+2:3];
    a0    = acks_seen;
    m0    = mem_en_cnt;
    i     = 0;
    cyc   = 0;
    first = -1;
    last  = -1;
    done  = 0;
    limit = 8 * n + 100;
    for (int j = 0; j < n; j++) begin
      d.push_back({$urandom, $urandom});
      exp_wr.push_back('{a: base + ADDR_W'(j), d: d[j]});
    end
    exp_err.push_back(1'b0);
    start_req(1'b1, a, n);
    while (!done) begin
      if (acks_seen != a0) done = 1;
      else if (cyc > limit) begin
        fail_event("wr_timeout");
        done = 1;
      end else begin
        if (i < n) begin
          wr_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
          wr_data  = d[i];
        end else begin
          // Stray valid data after the last beat must not reach memory.
          wr_valid = 1'($urandom_range(0, 1));
          wr_data  = {$urandom, $urandom};
        end
        @(negedge clk);
        if (wr_valid && wr_ready && i < n) begin
          ref_mem[base + ADDR_W'(i)] = d[i];
          if (first < 0) first = cyc_cnt;
          last = cyc_cnt;
          i++;
          if (abort_k > 0 && i == abort_k) begin
            // Let this beat land, then reset mid-cycle while valid is still high.
            @(posedge clk); #2;
            rst_n = 1'b0;
            #1;
            check_all_zero("rst");
            wr_valid = 1'b0;
            req      = 1'b0;
            exp_wr.delete();
            exp_err.delete();
            exp_rd.delete();
            repeat (2) @(posedge clk);
            #3 rst_n = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            chk("rst_no_ack", 64'(acks_seen), 64'(a0));
            chk("rst_beats_written", 64'(mem_en_cnt - m0), 64'(abort_k));
            return;
          end
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    wr_valid = 1'b0;
    chk("wr_beats", 64'(i), 64'(n));
    chk("wr_mem_en", 64'(mem_en_cnt - m0), 64'(n));
    if (!gaps) chk("wr_burst_span", 64'(last - first), 64'(n - 1));
    chk("wr_ack_latency", 64'(ack_cyc), 64'(last + 1));
    finish_req();
  endtask

  // mode 0: rd_ready always high; 1: random; 2: beat 2 stalled 5 cycles
  task automatic do_read(input logic [47:0] a, input int n, input int mode);
    logic [ADDR_W-1:0] base;
    int a0, m0, i, cyc, stall, prev_hs, limit;
    bit done;
    base    = a[ADDR_W+2:3];
    a0      = acks_seen;
    m0      = mem_en_cnt;
    i       = 0;
    cyc     = 0;
    stall   = 0;
    prev_hs = -1;
    done    = 0;
    limit   = 8 * n + 100;
    for (int j = 0; j < n; j++) exp_rd.push_back(ref_mem[base + ADDR_W'(j)]);
    exp_err.push_back(1'b0);
    start_req(1'b0, a, n);
    while (!done) begin
      if (acks_seen != a0) done = 1;
      else if (cyc > limit) begin
        fail_event("rd_timeout");
        done = 1;
      end else begin
        case (mode)
          0:       rd_ready = 1'b1;
          1:       rd_ready = 1'($urandom_range(0, 1));
          default: rd_ready = !(i == 1 && stall < 5);
        endcase
        @(negedge clk);
        if (rd_valid && !rd_ready) stall++;
        if (rd_valid && rd_ready) begin
          if (mode == 0 && prev_hs >= 0) chk("rd_spacing", 64'(cyc_cnt - prev_hs), 64'(3));
          prev_hs = cyc_cnt;
          i++;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    rd_ready = 1'b0;
    chk("rd_beats", 64'(i), 64'(n));
    chk("rd_mem_en", 64'(mem_en_cnt - m0), 64'(n));
    if (mode == 2) chk("rd_stall_cycles", 64'(stall), 64'(5));
    finish_req();
  endtask

  task automatic do_err(input logic w, input logic [47:0] a, input int n);
    int a0, m0;
    a0 = acks_seen;
    m0 = mem_en_cnt;
    exp_err.push_back(1'b1);
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    start_req(w, a, n);
    chk("rej_ack", 64'(ack), 64'(1));
    chk("rej_err", 64'(err), 64'(1));
    @(posedge clk); #1;
    chk("rej_ack_count", 64'(acks_seen - a0), 64'(1));
    chk("rej_mem_en", 64'(mem_en_cnt - m0), 64'(0));
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    finish_req();
  endtask

  function automatic logic [47:0] rand_addr();
    return {16'($urandom), 16'($urandom), ADDR_W'($urandom), 3'b000};
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    req      = 1'b0;
    rw       = 1'b0;
    addr     = '0;
    len      = '0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      sram[j]    = {$urandom, $urandom};
      ref_mem[j] = sram[j];
    end
    #1;
    check_all_zero("init");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    do_write(48'h40, 4, 1'b0, 0);
    do_read(48'h40, 4, 0);
    do_read(48'h40, 4, 2);
    do_err(1'b1, 48'h40, 0);
    do_err(1'b0, 48'h40, MAX_LEN + 1);
    do_err(1'b1, 48'h44, 4);
    do_write(48'(8190 << 3), 4, 1'b0, 0);
    do_read(48'(8190 << 3), 4, 1);
    do_write(48'h100, 4, 1'b0, 2);
    do_read(48'h100, 1, 0);
    do_read(48'h100, 3, 0);

    for (int t = 0; t < 16; t++) begin
      logic [47:0] ra;
      int rn;
      ra = rand_addr();
      rn = $urandom_range(1, 8);
      case ($urandom_range(0, 3))
        0:       do_write(ra, rn, 1'($urandom_range(0, 1)), 0);
        1:       do_read(ra, rn, $urandom_range(0, 2));
        2:       do_err(1'($urandom), ra | 48'($urandom_range(1, 7)), rn);
        default: begin
          do_write(ra, rn, 1'b1, 0);
          do_read(ra, rn, 1);
        end
      endcase
    end

    do_write(48'h0, MAX_LEN, 1'b0, 0);
    do_read(48'h1238, 5, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_wr_empty", 64'(exp_wr.size()), 64'(0));
    chk("sb_rd_empty", 64'(exp_rd.size()), 64'(0));
    chk("sb_ack_empty", 64'(exp_err.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
